// File: rtl/axil_ctl_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite control master.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package axil_ctl_pkg;

  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } axil_st_t;

endpackage

// File: rtl/axil_ctl_rr_arb2.sv
// Two-input round-robin arbiter; one-hot grant, last winner loses a tie.
// Latency: grant is combinational from req; pointer updates on the advance edge.
// Backpressure: none, grant is only consumed when advance is high.
module rr_arb2
  import axil_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Remembers which requester won last; reset value 1 hands requester 0 the first tie.
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/axil_ctl_shared_master.sv
// Round-robin shares one AXI4-Lite master port between two single-word requesters.
// Latency: ack 3 cycles after request with a zero-wait slave, plus slave stalls.
// Backpressure: requests wait while busy; AXI valids hold until their own handshake.
module axil_ctl_shared_master
  import axil_ctl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = AXIL_DATA_W
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            rq_req,
  input  logic [1:0]            rq_we,
  input  logic [2*ADDR_W-1:0]   rq_addr,
  input  logic [2*DATA_W-1:0]   rq_wdata,
  input  logic [7:0]            rq_wstrb,
  output logic [1:0]            rq_ack,
  output logic [DATA_W-1:0]     rq_rdata,
  output logic [1:0]            rq_resp,
  output logic                  busy,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  axil_st_t          state;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              grant_en;
  logic              g_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wstrb;

  // The ack cycle is spent in IDLE but may not grant: the acked requester still holds rq_req.
  assign grant_en  = (state == ST_IDLE) && (rq_ack == 2'b00) && (gnt != 2'b00);
  assign gnt_idx   = gnt[1];
  assign sel_we    = gnt_idx ? rq_we[1] : rq_we[0];
  assign sel_addr  = (gnt_idx ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0]) & ADDR_MASK;
  assign sel_wdata = gnt_idx ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
  assign sel_wstrb = gnt_idx ? rq_wstrb[7:4] : rq_wstrb[3:0];

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  rr_arb2 u_arb (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .req     (rq_req),
    .advance (grant_en),
    .gnt     (gnt)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      g_q           <= 1'b0;
      rq_ack        <= 2'b00;
      rq_rdata      <= '0;
      rq_resp       <= RESP_OKAY;
      busy          <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= 4'h0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      rq_ack <= 2'b00;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (grant_en) begin
            busy <= 1'b1;
            g_q  <= gnt_idx;
            if (sel_we) begin
              M_AXI_AWADDR  <= sel_addr;
              M_AXI_WDATA   <= sel_wdata;
              M_AXI_WSTRB   <= sel_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= ST_WADDR;
            end else begin
              M_AXI_ARADDR  <= sel_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= ST_RADDR;
            end
          end
        end
        ST_WADDR: begin
          // AW and W retire independently; leave once neither is still pending.
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rq_resp      <= M_AXI_BRESP;
            rq_rdata     <= '0;
            rq_ack       <= g_q ? 2'b10 : 2'b01;
            state        <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rq_rdata     <= M_AXI_RDATA;
            rq_resp      <= M_AXI_RRESP;
            rq_ack       <= g_q ? 2'b10 : 2'b01;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ctl_shared_master.sv
// Directed bench for axil_ctl_shared_master with a configurable-stall AXI4-Lite slave model.
module tb_axil_ctl_shared_master;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  rq_req, rq_we;
  logic [63:0] rq_addr, rq_wdata;
  logic [7:0]  rq_wstrb;
  logic [1:0]  rq_ack, rq_resp;
  logic [31:0] rq_rdata;
  logic        busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axil_ctl_shared_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
    .rq_ack(rq_ack), .rq_rdata(rq_rdata), .rq_resp(rq_resp), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave model: cfg_* set by the test, everything else owned by the negedge process.
  int unsigned cfg_dly_a = 0, cfg_dly_w = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] mem [16];
  bit          mem_done = 1'b0;
  logic        aw_got, w_got, ar_got, aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic        prev_awv, prev_wv, prev_arv;
  int unsigned aw_wait, w_wait, ar_wait;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;
  int          viol = 0, n_aw = 0, n_ar = 0, ack_cnt0 = 0, ack_cnt1 = 0;

  always @(negedge tb_ACLK) begin
    if (!mem_done) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem_done = 1'b1;
    end
    if (!ARESETN) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_fire = 0; w_fire = 0; ar_fire = 0;
      b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
      prev_awv = 0; prev_wv = 0; prev_arv = 0;
      aw_addr_l = 0; w_data_l = 0; w_strb_l = 0; ar_addr_l = 0;
    end else begin
      if (prev_awv && !aw_fire && !M_AXI_AWVALID) viol++;
      if (prev_wv && !w_fire && !M_AXI_WVALID) viol++;
      if (prev_arv && !ar_fire && !M_AXI_ARVALID) viol++;
      if (!prev_awv && !prev_wv && (M_AXI_AWVALID != M_AXI_WVALID)) viol++;
      if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) && (M_AXI_ARVALID || M_AXI_RREADY)) viol++;
      if ((M_AXI_AWVALID && M_AXI_AWADDR[1:0] != 2'b00) || (M_AXI_ARVALID && M_AXI_ARADDR[1:0] != 2'b00)) viol++;
      if (rq_ack == 2'b11) viol++;
      if (rq_ack[0]) ack_cnt0++;
      if (rq_ack[1]) ack_cnt1++;
      // retire handshakes that completed at the previous posedge
      if (b_fire) begin M_AXI_BVALID = 0; aw_got = 0; w_got = 0; end
      if (r_fire) begin M_AXI_RVALID = 0; ar_got = 0; end
      if (aw_fire) begin aw_got = 1; n_aw++; end
      if (w_fire) w_got = 1;
      if (ar_fire) begin ar_got = 1; n_ar++; end
      if (M_AXI_AWVALID && !aw_got) begin M_AXI_AWREADY = (aw_wait >= cfg_dly_a); aw_wait++; end
      else begin M_AXI_AWREADY = 0; aw_wait = 0; end
      if (M_AXI_WVALID && !w_got) begin M_AXI_WREADY = (w_wait >= cfg_dly_w); w_wait++; end
      else begin M_AXI_WREADY = 0; w_wait = 0; end
      if (M_AXI_ARVALID && !ar_got) begin M_AXI_ARREADY = (ar_wait >= cfg_dly_a); ar_wait++; end
      else begin M_AXI_ARREADY = 0; ar_wait = 0; end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) mem[aw_addr_l[5:2]][8*b +: 8] = w_data_l[8*b +: 8];
        M_AXI_BVALID = 1; M_AXI_BRESP = cfg_resp;
      end
      if (ar_got && !M_AXI_RVALID) begin
        M_AXI_RVALID = 1; M_AXI_RDATA = mem[ar_addr_l[5:2]]; M_AXI_RRESP = cfg_resp;
      end
      aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
      w_fire  = M_AXI_WVALID && M_AXI_WREADY;
      ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
      b_fire  = M_AXI_BVALID && M_AXI_BREADY;
      r_fire  = M_AXI_RVALID && M_AXI_RREADY;
      if (aw_fire) aw_addr_l = M_AXI_AWADDR;
      if (w_fire) begin w_data_l = M_AXI_WDATA; w_strb_l = M_AXI_WSTRB; end
      if (ar_fire) ar_addr_l = M_AXI_ARADDR;
      prev_awv = M_AXI_AWVALID; prev_wv = M_AXI_WVALID; prev_arv = M_AXI_ARVALID;
    end
  end

  typedef struct {
    int unsigned id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned dly_a;
    int unsigned dly_w;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input int unsigned id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int unsigned da, input int unsigned dw, input logic [1:0] sresp,
                              input logic [31:0] erd, input logic [1:0] ers, input int lat);
    vec_t v;
    v.id = id; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.dly_a = da; v.dly_w = dw; v.sresp = sresp;
    v.exp_rdata = erd; v.exp_resp = ers; v.exp_lat = lat;
    return v;
  endfunction

  task automatic wait_ack(output int lat, output logic [1:0] ack, output logic [31:0] rd,
                          output logic [1:0] rs, output logic bz);
    lat = 0; ack = 2'b00; rd = 32'h0; rs = 2'b00; bz = 1'b0;
    while (ack == 2'b00 && lat < 60) begin
      @(negedge tb_ACLK);
      lat++;
      ack = rq_ack; rd = rq_rdata; rs = rq_resp; bz = busy;
    end
    if (ack == 2'b00) begin
      n_chk++;
      $display("FAIL ack_timeout: no rq_ack after %0d cycles, one required", lat);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int lat, aw0, ar0;
    logic [1:0] ack, rs;
    logic [31:0] rd;
    logic bz;
    cfg_dly_a = v.dly_a; cfg_dly_w = v.dly_w; cfg_resp = v.sresp;
    rq_we[v.id] = v.we;
    rq_addr[v.id*32 +: 32] = v.addr;
    rq_wdata[v.id*32 +: 32] = v.wdata;
    rq_wstrb[v.id*4 +: 4] = v.wstrb;
    aw0 = n_aw; ar0 = n_ar;
    rq_req[v.id] = 1'b1;
    wait_ack(lat, ack, rd, rs, bz);
    rq_req = 2'b00;
    chk($sformatf("v%0d_ack", n), ack, (v.id == 1) ? 2'b10 : 2'b01);
    chk($sformatf("v%0d_rdata", n), rd, v.exp_rdata);
    chk($sformatf("v%0d_resp", n), rs, v.exp_resp);
    chk($sformatf("v%0d_latency", n), lat, v.exp_lat);
    chk($sformatf("v%0d_busy_at_ack", n), bz, 1'b1);
    chk($sformatf("v%0d_addr_handshakes", n), v.we ? (n_aw - aw0) : (n_ar - ar0), 1);
    if (v.we) chk($sformatf("v%0d_wstrb", n), w_strb_l, v.wstrb);
    @(negedge tb_ACLK);
    chk($sformatf("v%0d_ack_one_cycle", n), rq_ack, 2'b00);
    chk($sformatf("v%0d_busy_after", n), busy, 1'b0);
  endtask

  initial begin
    int exp_a0, exp_a1, gap, a0, a1, rem0, rem1;
    logic exp_g, g, got;
    logic [1:0] reraise;

    ARESETN = 1'b0; rq_req = 2'b00; rq_we = 2'b00;
    rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
    repeat (2) @(negedge tb_ACLK);
    chk("rst_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, busy, rq_ack}, 64'h0);
    chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
    chk("rst_wdat", {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, 64'h0);
    chk("rst_resp", {rq_rdata, rq_resp}, 64'h0);
    ARESETN = 1'b1;
    @(negedge tb_ACLK);

    //          id we addr        wdata         strb  da dw rsp  exp_rdata     rsp  lat
    tbl[0]  = mk(0, 1, 32'h00, 32'h0101FFFF, 4'hF, 0, 0, 2'b00, 32'h0,        2'b00, 3);
    tbl[1]  = mk(1, 1, 32'h04, 32'hABCD0001, 4'hF, 0, 0, 2'b00, 32'h0,        2'b00, 3);
    tbl[2]  = mk(1, 1, 32'h08, 32'hDEAD0011, 4'hF, 0, 0, 2'b00, 32'h0,        2'b00, 3);
    tbl[3]  = mk(1, 1, 32'h0C, 32'hBEEF0011, 4'hF, 0, 0, 2'b00, 32'h0,        2'b00, 3);
    tbl[4]  = mk(1, 0, 32'h04, 32'h0,        4'h0, 0, 0, 2'b00, 32'hABCD0001, 2'b00, 3);
    tbl[5]  = mk(1, 0, 32'h08, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEAD0011, 2'b00, 3);
    tbl[6]  = mk(1, 0, 32'h0C, 32'h0,        4'h0, 0, 0, 2'b00, 32'hBEEF0011, 2'b00, 3);
    tbl[7]  = mk(0, 0, 32'h00, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0101FFFF, 2'b00, 3);
    tbl[8]  = mk(0, 1, 32'h10, 32'h11223344, 4'hF, 0, 3, 2'b00, 32'h0,        2'b00, 6);
    tbl[9]  = mk(0, 1, 32'h14, 32'h55667788, 4'hF, 3, 0, 2'b00, 32'h0,        2'b00, 6);
    tbl[10] = mk(1, 0, 32'h10, 32'h0,        4'h0, 0, 0, 2'b00, 32'h11223344, 2'b00, 3);
    tbl[11] = mk(0, 1, 32'h1B, 32'hCAFEBABE, 4'h3, 0, 0, 2'b00, 32'h0,        2'b00, 3);
    tbl[12] = mk(1, 0, 32'h18, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0000BABE, 2'b00, 3);
    tbl[13] = mk(0, 1, 32'h20, 32'h00000001, 4'hF, 0, 0, 2'b10, 32'h0,        2'b10, 3);
    tbl[14] = mk(1, 0, 32'h20, 32'h0,        4'h0, 0, 0, 2'b11, 32'h00000001, 2'b11, 3);
    tbl[15] = mk(0, 0, 32'h14, 32'h0,        4'h0, 2, 0, 2'b00, 32'h55667788, 2'b00, 5);

    exp_a0 = 0; exp_a1 = 0;
    for (int i = 0; i < 16; i++) begin
      run_vec(i, tbl[i]);
      if (tbl[i].id == 1) exp_a1++; else exp_a0++;
    end

    // Reset while ARVALID is stalled: everything drops at once, no ack follows.
    cfg_dly_a = 20; cfg_resp = 2'b00;
    rq_we[0] = 1'b0; rq_addr[31:0] = 32'h00; rq_req[0] = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    chk("rstmid_arvalid_before", M_AXI_ARVALID, 1'b1);
    chk("rstmid_busy_before", busy, 1'b1);
    a0 = ack_cnt0; a1 = ack_cnt1;
    #2 ARESETN = 1'b0;
    #1;
    chk("rstmid_arvalid_async", M_AXI_ARVALID, 1'b0);
    chk("rstmid_busy_async", busy, 1'b0);
    chk("rstmid_ack_async", rq_ack, 2'b00);
    rq_req = 2'b00;
    repeat (3) @(negedge tb_ACLK);
    ARESETN = 1'b1; cfg_dly_a = 0;
    repeat (4) @(negedge tb_ACLK);
    chk("rstmid_no_ack", ack_cnt0 + ack_cnt1, a0 + a1);

    // Contention: both requesters always pending, reads of 0x0 and 0x4; requester 0 first after reset.
    rq_we = 2'b00;
    rq_addr = {32'h04, 32'h00};
    rem0 = 4; rem1 = 4; exp_g = 1'b0; reraise = 2'b00;
    rq_req = 2'b11;
    for (int n = 0; n < 8; n++) begin
      gap = 0; got = 1'b0;
      while (!got && gap < 60) begin
        @(negedge tb_ACLK);
        gap++;
        if (reraise != 2'b00) begin rq_req = rq_req | reraise; reraise = 2'b00; end
        if (rq_ack != 2'b00) got = 1'b1;
      end
      if (!got) begin
        n_chk++;
        $display("FAIL con_timeout: no rq_ack for command %0d, one required", n);
        break;
      end
      g = rq_ack[1];
      chk($sformatf("con%0d_grant", n), rq_ack, exp_g ? 2'b10 : 2'b01);
      chk($sformatf("con%0d_rdata", n), rq_rdata, g ? 32'hABCD0001 : 32'h0101FFFF);
      chk($sformatf("con%0d_gap", n), gap, (n == 0) ? 3 : 4);
      rq_req[g] = 1'b0;
      if (g) rem1--; else rem0--;
      if ((g ? rem1 : rem0) > 0) reraise[g] = 1'b1;
      exp_g = ~exp_g;
    end
    rq_req = 2'b00;
    repeat (3) @(negedge tb_ACLK);

    chk("protocol_violations", viol, 0);
    chk("ack_total_rq0", ack_cnt0, exp_a0 + 4);
    chk("ack_total_rq1", ack_cnt1, exp_a1 + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
